// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control path: opcodes, ALU/ImmSrc/ResultSrc codes, ctrl bundle layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // E-stage bundle layout
    localparam int E_REGWRITE = 0;
    localparam int E_MEMWRITE = 1;
    localparam int E_BRANCH   = 2;
    localparam int E_JUMP     = 3;
    localparam int E_JALR     = 4;
    localparam int E_ALUSRC   = 5;
    localparam int E_ILLEGAL  = 6;
    localparam int E_RES      = 7;
    localparam int E_ALU      = 9;
    localparam int E_F3       = 13;
    localparam int E_W        = 16;

    // M-stage and W-stage bundle layouts
    localparam int M_REGWRITE = 0;
    localparam int M_MEMWRITE = 1;
    localparam int M_RES      = 2;
    localparam int M_W        = 4;
    localparam int W_REGWRITE = 0;
    localparam int W_RES      = 1;
    localparam int W_W        = 3;

    // SUB only exists for R-type; SRA for both R and I shifts
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/branch_resolver.sv
// Resolves RV32I branch conditions and jumps from E-stage state into PCSrcE.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module branch_resolver #(
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic [2:0] funct3E,
    input  logic       ZeroE,
    input  logic       NegE,
    input  logic       OvfE,
    input  logic       CarryE,
    input  logic       BranchE,
    input  logic       JumpE,
    output logic       PCSrcE
);

    logic taken;
    logic lt;

    assign lt = NegE ^ OvfE;

    always_comb begin
        taken = 1'b0;
        case (funct3E)
            3'b000:  taken = ZeroE;
            3'b001:  taken = !ZeroE;
            3'b100:  taken = BRANCH_EXT && lt;
            3'b101:  taken = BRANCH_EXT && !lt;
            3'b110:  taken = BRANCH_EXT && !CarryE;
            3'b111:  taken = BRANCH_EXT && CarryE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE = JumpE | (BranchE & taken);

endmodule

// File: rtl/pipelined_control_unit.sv
// RV32I control unit: decodes in D and carries the ctrl bundle through E/M/W registers.
// Latency: D->E, E->M, M->W one cycle each; PCSrcE combinational from E state.
// Backpressure: no stalls; FlushE replaces the D->E capture with a bubble.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int RESULTSRC_W = 2,
    parameter int ALUCTRL_W   = 4,
    parameter bit BRANCH_EXT  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             OpD,
    input  logic [2:0]             funct3D,
    input  logic [6:0]             funct7D,
    input  logic                   FlushE,
    input  logic                   ZeroE,
    input  logic                   NegE,
    input  logic                   OvfE,
    input  logic                   CarryE,
    output logic [2:0]             ImmSrcD,
    output logic [ALUCTRL_W-1:0]   ALUControlE,
    output logic                   ALUSrcE,
    output logic [RESULTSRC_W-1:0] ResultSrcE,
    output logic                   RegWriteM,
    output logic                   MemWriteM,
    output logic                   RegWriteW,
    output logic [RESULTSRC_W-1:0] ResultSrcW,
    output logic                   PCSrcE,
    output logic                   JalrE,
    output logic                   IllegalE
);

    logic [E_W-1:0] dec_e;
    logic [E_W-1:0] e_q;
    logic [M_W-1:0] m_q;
    logic [W_W-1:0] w_q;
    logic           unused_f7;

    assign unused_f7 = ^{funct7D[6], funct7D[4:0]};

    always_comb begin
        dec_e             = '0;
        ImmSrcD           = IMM_I;
        dec_e[E_F3 +: 3]  = funct3D;
        dec_e[E_ALU +: 4] = ALU_ADD;
        case (OpD)
            OP_R: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_ALU +: 4] = alu_decode(funct3D, funct7D[5], 1'b1);
            end
            OP_I: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_ALUSRC]   = 1'b1;
                dec_e[E_ALU +: 4] = alu_decode(funct3D, funct7D[5], 1'b0);
            end
            OP_LOAD: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_ALUSRC]   = 1'b1;
                dec_e[E_RES +: 2] = RES_MEM;
            end
            OP_STORE: begin
                dec_e[E_MEMWRITE] = 1'b1;
                dec_e[E_ALUSRC]   = 1'b1;
                ImmSrcD           = IMM_S;
            end
            OP_BRANCH: begin
                dec_e[E_BRANCH]   = 1'b1;
                dec_e[E_ALU +: 4] = ALU_SUB;
                ImmSrcD           = IMM_B;
            end
            OP_JAL: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_JUMP]     = 1'b1;
                dec_e[E_RES +: 2] = RES_PC4;
                ImmSrcD           = IMM_J;
            end
            OP_JALR: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_JUMP]     = 1'b1;
                dec_e[E_JALR]     = 1'b1;
                dec_e[E_ALUSRC]   = 1'b1;
                dec_e[E_RES +: 2] = RES_PC4;
            end
            OP_LUI, OP_AUIPC: begin
                dec_e[E_REGWRITE] = 1'b1;
                dec_e[E_ALUSRC]   = 1'b1;
                ImmSrcD           = IMM_U;
            end
            default: begin
                dec_e[E_ILLEGAL]  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= FlushE ? '0 : dec_e;
            m_q <= {e_q[E_RES +: 2], e_q[E_MEMWRITE], e_q[E_REGWRITE]};
            w_q <= {m_q[M_RES +: 2], m_q[M_REGWRITE]};
        end
    end

    always_comb begin
        ALUControlE        = '0;
        ALUControlE[3:0]   = e_q[E_ALU +: 4];
        ResultSrcE         = '0;
        ResultSrcE[1:0]    = e_q[E_RES +: 2];
        ResultSrcW         = '0;
        ResultSrcW[1:0]    = w_q[W_RES +: 2];
    end

    assign ALUSrcE   = e_q[E_ALUSRC];
    assign JalrE     = e_q[E_JALR];
    assign IllegalE  = e_q[E_ILLEGAL];
    assign RegWriteM = m_q[M_REGWRITE];
    assign MemWriteM = m_q[M_MEMWRITE];
    assign RegWriteW = w_q[W_REGWRITE];

    branch_resolver #(.BRANCH_EXT(BRANCH_EXT)) u_branch (
        .funct3E (e_q[E_F3 +: 3]),
        .ZeroE   (ZeroE),
        .NegE    (NegE),
        .OvfE    (OvfE),
        .CarryE  (CarryE),
        .BranchE (e_q[E_BRANCH]),
        .JumpE   (e_q[E_JUMP]),
        .PCSrcE  (PCSrcE)
    );

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed-vector bench for pipelined_control_unit; a second instance is built with BRANCH_EXT=0.
module tb_pipelined_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] OpD;
    logic [2:0] funct3D;
    logic [6:0] funct7D;
    logic       FlushE, ZeroE, NegE, OvfE, CarryE;

    logic [2:0] ImmSrcD;
    logic [3:0] ALUControlE;
    logic       ALUSrcE;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW;
    logic       PCSrcE, JalrE, IllegalE;

    logic [2:0] n_ImmSrcD;
    logic [3:0] n_ALUControlE;
    logic       n_ALUSrcE;
    logic [1:0] n_ResultSrcE;
    logic       n_RegWriteM, n_MemWriteM, n_RegWriteW;
    logic [1:0] n_ResultSrcW;
    logic       n_PCSrcE, n_JalrE, n_IllegalE;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] BAD = 7'b1111111;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .OpD(OpD), .funct3D(funct3D), .funct7D(funct7D),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .PCSrcE(PCSrcE),
        .JalrE(JalrE), .IllegalE(IllegalE)
    );

    pipelined_control_unit #(.BRANCH_EXT(1'b0)) dut_nx (
        .clk(clk), .rst(rst), .OpD(OpD), .funct3D(funct3D), .funct7D(funct7D),
        .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(n_ImmSrcD), .ALUControlE(n_ALUControlE), .ALUSrcE(n_ALUSrcE),
        .ResultSrcE(n_ResultSrcE), .RegWriteM(n_RegWriteM), .MemWriteM(n_MemWriteM),
        .RegWriteW(n_RegWriteW), .ResultSrcW(n_ResultSrcW), .PCSrcE(n_PCSrcE),
        .JalrE(n_JalrE), .IllegalE(n_IllegalE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        OpD = op; funct3D = f3; funct7D = f7;
    endtask

    initial begin
        rst = 1'b0; FlushE = 0; ZeroE = 0; NegE = 0; OvfE = 0; CarryE = 0;
        drive(R, 3'b000, 7'b0000000);
        repeat (3) tick();
        chk("rst_alu",    ALUControlE, 0);
        chk("rst_alusrc", ALUSrcE, 0);
        chk("rst_rse",    ResultSrcE, 0);
        chk("rst_rwm",    RegWriteM, 0);
        chk("rst_mwm",    MemWriteM, 0);
        chk("rst_rww",    RegWriteW, 0);
        chk("rst_rsw",    ResultSrcW, 0);
        chk("rst_pcsrc",  PCSrcE, 0);
        chk("rst_jalr",   JalrE, 0);
        chk("rst_ill",    IllegalE, 0);

        // release reset with add held in D
        rst = 1'b1;
        tick();
        chk("add_alu_e", ALUControlE, 0);
        chk("add_rww_1", RegWriteW, 0);
        tick();
        chk("add_rwm_2", RegWriteM, 1);
        chk("add_rww_2", RegWriteW, 0);
        tick();
        chk("add_rww_3", RegWriteW, 1);
        chk("add_rsw_3", ResultSrcW, 0);

        drive(R, 3'b000, 7'b0100000);
        tick();
        chk("sub_alu_e", ALUControlE, 1);
        drive(R, 3'b101, 7'b0100000);
        tick();
        chk("sra_alu_e", ALUControlE, 9);
        drive(R, 3'b101, 7'b0000000);
        tick();
        chk("srl_alu_e", ALUControlE, 8);
        drive(7'b0010011, 3'b000, 7'b0100000);
        tick();
        chk("addi_f7_alu_e", ALUControlE, 0);
        chk("addi_alusrc", ALUSrcE, 1);

        // store then load
        drive(ST, 3'b010, 7'b0000000);
        #1 chk("sw_imm", ImmSrcD, 1);
        tick();
        chk("sw_alusrc", ALUSrcE, 1);
        drive(LD, 3'b010, 7'b0000000);
        #1 chk("lw_imm", ImmSrcD, 0);
        tick();
        chk("lw_rse",  ResultSrcE, 1);
        chk("sw_mwm",  MemWriteM, 1);
        chk("sw_rwm",  RegWriteM, 0);
        drive(BR, 3'b000, 7'b0000000);
        #1 chk("br_imm", ImmSrcD, 2);
        tick();
        chk("lw_rwm",  RegWriteM, 1);
        chk("lw_mwm",  MemWriteM, 0);
        chk("beq_alu", ALUControlE, 1);

        // branches: beq in E
        ZeroE = 1; #1;
        chk("beq_z1",    PCSrcE, 1);
        chk("beq_z1_nx", n_PCSrcE, 1);
        ZeroE = 0; #1;
        chk("beq_z0",    PCSrcE, 0);
        drive(BR, 3'b110, 7'b0000000);
        tick();
        CarryE = 0; #1;
        chk("bltu_c0",    PCSrcE, 1);
        chk("bltu_c0_nx", n_PCSrcE, 0);
        CarryE = 1; #1;
        chk("bltu_c1",    PCSrcE, 0);
        drive(BR, 3'b100, 7'b0000000);
        tick();
        NegE = 1; OvfE = 0; #1;
        chk("blt_lt",  PCSrcE, 1);
        OvfE = 1; #1;
        chk("blt_ge",  PCSrcE, 0);
        NegE = 0; OvfE = 0;
        drive(BR, 3'b010, 7'b0000000);
        tick();
        ZeroE = 1; #1;
        chk("b010_never", PCSrcE, 0);

        // flushed jal: bubble in E with ZeroE=1
        drive(JL, 3'b000, 7'b0000000);
        FlushE = 1;
        #1 chk("jal_imm", ImmSrcD, 3);
        tick();
        chk("flush_pcsrc", PCSrcE, 0);
        chk("flush_jalr",  JalrE, 0);
        FlushE = 0; ZeroE = 0;
        drive(BR, 3'b000, 7'b0000000);
        tick();
        chk("flush_rwm", RegWriteM, 0);
        tick();
        chk("flush_rww", RegWriteW, 0);

        // unflushed jal then jalr
        drive(JL, 3'b000, 7'b0000000);
        tick();
        chk("jal_pcsrc", PCSrcE, 1);
        chk("jal_jalr",  JalrE, 0);
        chk("jal_rse",   ResultSrcE, 2);
        drive(JR, 3'b000, 7'b0000000);
        tick();
        chk("jalr_jalr",  JalrE, 1);
        chk("jalr_pcsrc", PCSrcE, 1);
        drive(BR, 3'b000, 7'b0000000);
        tick();
        chk("jal_rsw", ResultSrcW, 2);
        chk("jal_rww", RegWriteW, 1);

        // illegal opcode
        drive(BAD, 3'b000, 7'b0000000);
        tick();
        chk("ill_e", IllegalE, 1);
        drive(BR, 3'b000, 7'b0000000);
        tick();
        chk("ill_one_cycle", IllegalE, 0);
        chk("ill_mwm", MemWriteM, 0);
        chk("ill_rwm", RegWriteM, 0);
        tick();
        chk("ill_rww", RegWriteW, 0);

        // async reset mid-cycle: lw in M, sw in E
        drive(LD, 3'b010, 7'b0000000);
        tick();
        drive(ST, 3'b010, 7'b0000000);
        tick();
        chk("pre_rst_rwm", RegWriteM, 1);
        drive(BR, 3'b000, 7'b0000000);
        #2 rst = 1'b0;
        #1;
        chk("arst_rwm",    RegWriteM, 0);
        chk("arst_alusrc", ALUSrcE, 0);
        chk("arst_mwm",    MemWriteM, 0);
        #2 rst = 1'b1;
        tick();
        chk("post_rst_mwm_1", MemWriteM, 0);
        tick();
        chk("post_rst_mwm_2", MemWriteM, 0);
        chk("post_rst_rww",   RegWriteW, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
